// File: rtl/deserializer_if.sv
// Serial-in / word-out bundle for the deserializer: the serial side is driven
// by the master, the reassembled-word side by the slave (the deserializer).
interface deserializer_if;
  logic        ser_data_i;
  logic        ser_data_val_i;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_data_mod_o;
  logic        deser_data_val_o;
  logic        busy_o;

  modport slave (
    input  ser_data_i,
    input  ser_data_val_i,
    output deser_data_o,
    output deser_data_mod_o,
    output deser_data_val_o,
    output busy_o
  );

  modport master (
    output ser_data_i,
    output ser_data_val_i,
    input  deser_data_o,
    input  deser_data_mod_o,
    input  deser_data_val_o,
    input  busy_o
  );
endinterface

// File: rtl/deserializer.sv
// MSB-first serial to 16-bit word deserializer with partial-word flush and runt drop.
// Optional runt_err_o pulse output is enabled by defining DESER_RUNT_ERR_EN.
module deserializer (
  input  logic           clk_i,
  input  logic           arst_n_i,
  deserializer_if.slave  bus
`ifdef DESER_RUNT_ERR_EN
  ,
  output logic           runt_err_o
`endif
);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  mod_q, mod_d;
  logic        val_q, val_d;
  logic        busy_q, busy_d;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ser_data_val_i) begin
          shift_d = {bus.ser_data_i, 15'd0};
          cnt_d   = 4'd1;
          state_d = COLLECT;
        end else begin
          shift_d = '0;
          cnt_d   = '0;
        end
      end

      COLLECT: begin
        if (bus.ser_data_val_i && (cnt_q != 4'd15)) begin
          shift_d[4'd15 - cnt_q] = bus.ser_data_i;
          cnt_d                  = cnt_q + 4'd1;
        end else begin
          // Every exit to IDLE clears shift so zero-filled LSBs stay clean.
          if (bus.ser_data_val_i) begin
            data_d = {shift_q[15:1], bus.ser_data_i};
            mod_d  = 4'd0;
            val_d  = 1'b1;
          end else if (cnt_q >= 4'd3) begin
            data_d = shift_q;
            mod_d  = cnt_q;
            val_d  = 1'b1;
          end
          shift_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == COLLECT);
  end

  assign bus.deser_data_o     = data_q;
  assign bus.deser_data_mod_o = mod_q;
  assign bus.deser_data_val_o = val_q;
  assign bus.busy_o           = busy_q;

`ifdef DESER_RUNT_ERR_EN
  logic runt_q, runt_d;

  always_comb begin
    runt_d = (state_q == COLLECT) && !bus.ser_data_val_i && (cnt_q < 4'd3);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) runt_q <= 1'b0;
    else           runt_q <= runt_d;
  end

  assign runt_err_o = runt_q;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: full words, partial words, runts,
// long-frame split, mid-frame reset and back-to-back short frames.
module tb_deserializer;

  logic clk_i;
  logic arst_n_i;
`ifdef DESER_RUNT_ERR_EN
  logic runt_err_o;
`endif

  deserializer_if bus ();

  deserializer dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .bus        (bus)
`ifdef DESER_RUNT_ERR_EN
    ,
    .runt_err_o (runt_err_o)
`endif
  );

  int total = 0;
  int bad   = 0;
  int npulse = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, let the edge happen, then sample 1 ns later.
  task automatic step(input logic v, input logic b);
    bus.ser_data_val_i = v;
    bus.ser_data_i     = b;
    @(posedge clk_i);
    #1;
    if (bus.deser_data_val_o === 1'b1) npulse++;
  endtask

  task automatic send_word(input logic [15:0] w, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) step(1'b1, w[15 - i]);
  endtask

  initial begin
    int p0;
    logic [15:0] w;

    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    arst_n_i           = 1'b0;
    #1;
    chk("rst_data", 32'(bus.deser_data_o), 32'h0);
    chk("rst_mod",  32'(bus.deser_data_mod_o), 32'h0);
    chk("rst_val",  32'(bus.deser_data_val_o), 32'h0);
    chk("rst_busy", 32'(bus.busy_o), 32'h0);
`ifdef DESER_RUNT_ERR_EN
    chk("rst_runt", 32'(runt_err_o), 32'h0);
`endif
    @(negedge clk_i);
    arst_n_i = 1'b1;
    step(1'b0, 1'b0);
    chk("idle_busy", 32'(bus.busy_o), 32'h0);

    // Full 16-bit word 0xA5C3
    p0 = npulse;
    w  = 16'hA5C3;
    send_word(w, 15);
    chk("a5_busy15", 32'(bus.busy_o), 32'h1);
    chk("a5_noval15", 32'(bus.deser_data_val_o), 32'h0);
    step(1'b1, w[0]);
    chk("a5_val",  32'(bus.deser_data_val_o), 32'h1);
    chk("a5_data", 32'(bus.deser_data_o), 32'hA5C3);
    chk("a5_mod",  32'(bus.deser_data_mod_o), 32'h0);
    chk("a5_busy", 32'(bus.busy_o), 32'h0);
    step(1'b0, 1'b0);
    chk("a5_val_off", 32'(bus.deser_data_val_o), 32'h0);
    chk("a5_hold",    32'(bus.deser_data_o), 32'hA5C3);
    chk("a5_pulses",  32'(npulse - p0), 32'h1);

    // Partial word 1,0,1,1,0
    send_word(16'hB000, 5);
    chk("b0_busy", 32'(bus.busy_o), 32'h1);
    step(1'b0, 1'b0);
    chk("b0_val",  32'(bus.deser_data_val_o), 32'h1);
    chk("b0_data", 32'(bus.deser_data_o), 32'hB000);
    chk("b0_mod",  32'(bus.deser_data_mod_o), 32'h5);
    chk("b0_busy_off", 32'(bus.busy_o), 32'h0);

    // Runt 1,1
    p0 = npulse;
    send_word(16'hC000, 2);
    step(1'b0, 1'b0);
    chk("runt_noval", 32'(bus.deser_data_val_o), 32'h0);
    chk("runt_hold",  32'(bus.deser_data_o), 32'hB000);
    chk("runt_mod",   32'(bus.deser_data_mod_o), 32'h5);
`ifdef DESER_RUNT_ERR_EN
    chk("runt_pulse", 32'(runt_err_o), 32'h1);
`endif
    step(1'b0, 1'b0);
`ifdef DESER_RUNT_ERR_EN
    chk("runt_pulse_off", 32'(runt_err_o), 32'h0);
`endif
    chk("runt_pulses", 32'(npulse - p0), 32'h0);

    // 20-bit frame: 0xFFFF then 1,0,1,0
    send_word(16'hFFFF, 16);
    chk("ff_val",  32'(bus.deser_data_val_o), 32'h1);
    chk("ff_data", 32'(bus.deser_data_o), 32'hFFFF);
    chk("ff_mod",  32'(bus.deser_data_mod_o), 32'h0);
    send_word(16'hA000, 1);
    chk("ff_b17_busy",  32'(bus.busy_o), 32'h1);
    chk("ff_b17_noval", 32'(bus.deser_data_val_o), 32'h0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("tail_val",  32'(bus.deser_data_val_o), 32'h1);
    chk("tail_data", 32'(bus.deser_data_o), 32'hA000);
    chk("tail_mod",  32'(bus.deser_data_mod_o), 32'h4);

    // Reset mid-frame, between edges
    p0 = npulse;
    send_word(16'h5A00, 8);
    #2;
    arst_n_i = 1'b0;
    #1;
    chk("mr_data", 32'(bus.deser_data_o), 32'h0);
    chk("mr_mod",  32'(bus.deser_data_mod_o), 32'h0);
    chk("mr_val",  32'(bus.deser_data_val_o), 32'h0);
    chk("mr_busy", 32'(bus.busy_o), 32'h0);
    bus.ser_data_val_i = 1'b0;
    @(negedge clk_i);
    arst_n_i = 1'b1;
    step(1'b0, 1'b0);
    chk("mr_after_val",  32'(bus.deser_data_val_o), 32'h0);
    chk("mr_after_busy", 32'(bus.busy_o), 32'h0);
    send_word(16'hC000, 4);
    step(1'b0, 1'b0);
    chk("c0_data", 32'(bus.deser_data_o), 32'hC000);
    chk("c0_mod",  32'(bus.deser_data_mod_o), 32'h4);
    chk("mr_pulses", 32'(npulse - p0), 32'h1);

    // Back-to-back 3-bit frames, one idle cycle apart
    send_word(16'hA000, 3);
    step(1'b0, 1'b0);
    chk("bb1_data", 32'(bus.deser_data_o), 32'hA000);
    chk("bb1_mod",  32'(bus.deser_data_mod_o), 32'h3);
    send_word(16'h6000, 3);
    chk("bb2_noval", 32'(bus.deser_data_val_o), 32'h0);
    step(1'b0, 1'b0);
    chk("bb2_val",  32'(bus.deser_data_val_o), 32'h1);
    chk("bb2_data", 32'(bus.deser_data_o), 32'h6000);
    chk("bb2_mod",  32'(bus.deser_data_mod_o), 32'h3);
    step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 Port clk_i SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port arst_n_i SHALL be an input, 1 bit wide: the asynchronous active-low reset.
REQ-004 Port ser_data_i SHALL be an input, 1 bit wide: the serial data bit, MSB first, sampled only when ser_data_val_i=1.
REQ-005 Port ser_data_val_i SHALL be an input, 1 bit wide: the frame qualifier; a frame is a contiguous run of cycles with this signal high.
REQ-006 Port deser_data_o SHALL be an output, 16 bits wide: the reassembled word, MSB-aligned, with unused LSBs zero.
REQ-007 Port deser_data_mod_o SHALL be an output, 4 bits wide: the number of valid bits in deser_data_o; 0 encodes 16.
REQ-008 Port deser_data_val_o SHALL be an output, 1 bit wide: a one-cycle pulse marking a new deser_data_o/deser_data_mod_o.
REQ-009 Port busy_o SHALL be an output, 1 bit wide: high while a word is partially collected.
REQ-010 Port runt_err_o SHALL be an output, 1 bit wide, and SHALL exist only when DESER_RUNT_ERR_EN is defined: a one-cycle pulse on a discarded runt segment.

Function
REQ-011 The block SHALL implement the FSM states IDLE and COLLECT, with a 4-bit bit counter cnt and a 16-bit shift register.
REQ-012 In IDLE with ser_data_val_i=1, the block SHALL load the bit into shift[15], set cnt=1 and go to COLLECT.
REQ-013 In COLLECT with ser_data_val_i=1 and cnt<15, the block SHALL place the bit at shift[15-cnt], increment cnt and stay in COLLECT.
REQ-014 In COLLECT with ser_data_val_i=1 and cnt==15, the block SHALL complete the word: deser_data_o = full shift including the new bit, deser_data_mod_o=0, deser_data_val_o=1 for the next cycle; it SHALL then go to IDLE with cnt=0.
REQ-015 In COLLECT with ser_data_val_i=0 and cnt>=3, the block SHALL emit a partial word: deser_data_o = shift with bits below position 16-cnt zero, deser_data_mod_o=cnt, deser_data_val_o=1; it SHALL then go to IDLE.
REQ-016 In COLLECT with ser_data_val_i=0 and cnt<3 (runt), the block SHALL drop the bits, produce no deser_data_val_o pulse, pulse runt_err_o when enabled, and go to IDLE.
REQ-017 Latency SHALL be one cycle: outputs update on the same edge that samples the 16th bit or the falling ser_data_val_i.
REQ-018 A frame longer than 16 bits SHALL be split with no gap: bit 17 is accepted in IDLE on the very next edge and starts a new word; each trailing segment follows REQ-015/016.
REQ-019 Back-to-back frames separated by a single low cycle SHALL be decoded independently without loss.
REQ-020 deser_data_o and deser_data_mod_o SHALL hold their values between pulses; deser_data_val_o SHALL never be high two cycles in a row unless two words complete on consecutive edges.
REQ-021 busy_o SHALL be registered and equal 1 exactly when the state is COLLECT.
REQ-022 The shift register SHALL be cleared on entry to IDLE so that no stale bits leak into the zero-filled LSBs.

Reset
REQ-023 On arst_n_i=0 the block SHALL immediately, regardless of the clock, set state=IDLE, cnt=0, shift=0, deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, busy_o=0 and runt_err_o=0.
REQ-024 When reset is asserted mid-frame, the partial word SHALL be discarded with no pulse; after deassertion, decoding SHALL restart at the next ser_data_val_i=1 cycle.
REQ-025 Deassertion SHALL be synchronous to clk_i at the integration level; the block itself contains no synchronizer.

Configuration
REQ-026 Macro DESER_RUNT_ERR_EN: when defined, the runt_err_o port and its pulse logic SHALL be present; when undefined, the port SHALL be absent and runts SHALL be silently dropped, with otherwise identical behaviour.

Verification
REQ-027 A bench SHALL drive 16 contiguous bits of 0xA5C3, then valid low, and SHALL see one pulse one cycle after the 16th bit with data 0xA5C3, mod 0, and busy_o falling on the same edge.
REQ-028 A bench SHALL drive bits 1,0,1,1,0, then valid low, and SHALL see data 0xB000 and mod 5.
REQ-029 A bench SHALL drive bits 1,1, then valid low, and SHALL see no deser_data_val_o; with DESER_RUNT_ERR_EN it SHALL see one runt_err_o pulse.
REQ-030 A bench SHALL drive 20 contiguous bits 0xFFFF followed by 1,0,1,0, and SHALL see 0xFFFF with mod 0, then 0xA000 with mod 4, with no bit lost.
REQ-031 A bench SHALL drive 8 bits, then assert arst_n_i low between clock edges, and SHALL see all outputs 0 immediately and no pulse; a following 4-bit frame 1,1,0,0 SHALL yield 0xC000 with mod 4.
REQ-032 A bench SHALL drive two 3-bit frames 1,0,1 and 0,1,1 separated by one idle cycle, and SHALL see 0xA000 with mod 3, then 0x6000 with mod 3.
